// File: rtl/execute_operand_stage_if.sv
// Operand-stage bundle: decode-side inputs, MEM/WB forwarding sources and ALU-facing outputs.
interface execute_operand_stage_if #(
  parameter int XLEN    = 32,
  parameter int REGADDR = 5
);
  logic               StallE;
  logic               FlushE;
  logic               ValidD;
  logic [XLEN-1:0]    RD1D;
  logic [XLEN-1:0]    RD2D;
  logic [REGADDR-1:0] Rs1D;
  logic [REGADDR-1:0] Rs2D;
  logic [REGADDR-1:0] RdD;
  logic [XLEN-1:0]    ImmExtD;
  logic [XLEN-1:0]    PCD;
  logic [3:0]         ALUControlD;
  logic               ALUSrcAD;
  logic               ALUSrcBD;
  logic               RegWriteD;
  logic [XLEN-1:0]    ALUResultM;
  logic [REGADDR-1:0] RdM;
  logic               RegWriteM;
  logic [XLEN-1:0]    ResultW;
  logic [REGADDR-1:0] RdW;
  logic               RegWriteW;
  logic [XLEN-1:0]    SrcA;
  logic [XLEN-1:0]    SrcB;
  logic [3:0]         ALUControl;
  logic [XLEN-1:0]    WriteDataE;
  logic [REGADDR-1:0] RdE;
  logic               RegWriteE;
  logic               ValidE;
  logic [XLEN-1:0]    PCE;
  logic [1:0]         ForwardAE;
  logic [1:0]         ForwardBE;

  modport master (
    output StallE, FlushE, ValidD, RD1D, RD2D, Rs1D, Rs2D, RdD, ImmExtD, PCD,
           ALUControlD, ALUSrcAD, ALUSrcBD, RegWriteD,
           ALUResultM, RdM, RegWriteM, ResultW, RdW, RegWriteW,
    input  SrcA, SrcB, ALUControl, WriteDataE, RdE, RegWriteE, ValidE, PCE,
           ForwardAE, ForwardBE
  );

  modport slave (
    input  StallE, FlushE, ValidD, RD1D, RD2D, Rs1D, Rs2D, RdD, ImmExtD, PCD,
           ALUControlD, ALUSrcAD, ALUSrcBD, RegWriteD,
           ALUResultM, RdM, RegWriteM, ResultW, RdW, RegWriteW,
    output SrcA, SrcB, ALUControl, WriteDataE, RdE, RegWriteE, ValidE, PCE,
           ForwardAE, ForwardBE
  );
endinterface

// File: rtl/execute_operand_stage.sv
// ID/EX register with MEM/WB operand forwarding (EXEC_FORWARDING_EN); E outputs one cycle after load.
// Operands are combinational off the stage regs; StallE holds, FlushE (wins over stall) loads a bubble.
module execute_operand_stage #(
  parameter int XLEN    = 32,
  parameter int REGADDR = 5
) (
  input logic                    clk,
  input logic                    rst,
  execute_operand_stage_if.slave eif
);

  typedef struct packed {
    logic               valid;
    logic [XLEN-1:0]    rd1;
    logic [XLEN-1:0]    rd2;
    logic [REGADDR-1:0] rs1;
    logic [REGADDR-1:0] rs2;
    logic [REGADDR-1:0] rd;
    logic [XLEN-1:0]    imm;
    logic [XLEN-1:0]    pc;
    logic [3:0]         alu_ctl;
    logic               src_a_pc;
    logic               src_b_imm;
    logic               reg_write;
  } stage_t;

  stage_t          st_q;
  stage_t          st_d;
  logic [1:0]      fwd_a;
  logic [1:0]      fwd_b;
  logic [XLEN-1:0] opnd_a;
  logic [XLEN-1:0] opnd_b;

  // An invalid decode slot loads as an all-zero bubble, same as a flush.
  always_comb begin
    st_d = '0;
    if (eif.ValidD) begin
      st_d.valid     = 1'b1;
      st_d.rd1       = eif.RD1D;
      st_d.rd2       = eif.RD2D;
      st_d.rs1       = eif.Rs1D;
      st_d.rs2       = eif.Rs2D;
      st_d.rd        = eif.RdD;
      st_d.imm       = eif.ImmExtD;
      st_d.pc        = eif.PCD;
      st_d.alu_ctl   = eif.ALUControlD;
      st_d.src_a_pc  = eif.ALUSrcAD;
      st_d.src_b_imm = eif.ALUSrcBD;
      st_d.reg_write = eif.RegWriteD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= '0;
    end else if (eif.FlushE) begin
      st_q <= '0;
    end else if (!eif.StallE) begin
      st_q <= st_d;
    end
  end

`ifdef EXEC_FORWARDING_EN
  // MEM is the younger producer, so it beats WB; x0 is never a forwarding target.
  function automatic logic [1:0] fwd_sel(
    input logic [REGADDR-1:0] rs,
    input logic               vld,
    input logic               wm,
    input logic [REGADDR-1:0] rdm,
    input logic               ww,
    input logic [REGADDR-1:0] rdw
  );
    fwd_sel = 2'b00;
    if (vld && wm && (rdm != '0) && (rdm == rs)) begin
      fwd_sel = 2'b10;
    end else if (vld && ww && (rdw != '0) && (rdw == rs)) begin
      fwd_sel = 2'b01;
    end
  endfunction

  assign fwd_a = fwd_sel(st_q.rs1, st_q.valid, eif.RegWriteM, eif.RdM, eif.RegWriteW, eif.RdW);
  assign fwd_b = fwd_sel(st_q.rs2, st_q.valid, eif.RegWriteM, eif.RdM, eif.RegWriteW, eif.RdW);

  always_comb begin
    case (fwd_a)
      2'b10:   opnd_a = eif.ALUResultM;
      2'b01:   opnd_a = eif.ResultW;
      default: opnd_a = st_q.rd1;
    endcase
    case (fwd_b)
      2'b10:   opnd_b = eif.ALUResultM;
      2'b01:   opnd_b = eif.ResultW;
      default: opnd_b = st_q.rd2;
    endcase
  end
`else
  // Without forwarding the hazard unit stalls every RAW hazard, so register-file data is final.
  logic unused_fwd;

  assign fwd_a      = 2'b00;
  assign fwd_b      = 2'b00;
  assign opnd_a     = st_q.rd1;
  assign opnd_b     = st_q.rd2;
  assign unused_fwd = ^{eif.ALUResultM, eif.RdM, eif.RegWriteM,
                        eif.ResultW, eif.RdW, eif.RegWriteW, st_q.rs1, st_q.rs2};
`endif

  assign eif.SrcA       = st_q.src_a_pc  ? st_q.pc  : opnd_a;
  assign eif.SrcB       = st_q.src_b_imm ? st_q.imm : opnd_b;
  assign eif.WriteDataE = opnd_b;
  assign eif.ALUControl = st_q.alu_ctl;
  assign eif.RdE        = st_q.rd;
  assign eif.RegWriteE  = st_q.reg_write;
  assign eif.ValidE     = st_q.valid;
  assign eif.PCE        = st_q.pc;
  assign eif.ForwardAE  = fwd_a;
  assign eif.ForwardBE  = fwd_b;

endmodule

// File: tb/tb_execute_operand_stage.sv
// Directed vectors for execute_operand_stage; expected E outputs are queued and checked on the falling edge.
module tb_execute_operand_stage;

`ifdef EXEC_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] srca;
    logic [31:0] srcb;
    logic [31:0] wd;
    logic [31:0] pc;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic        rw;
    logic        v;
    logic [1:0]  fa;
    logic [1:0]  fb;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  int    checks = 0;
  int    errors = 0;
  exp_t  exp_q[$];
  string tag_q[$];

  execute_operand_stage_if #(.XLEN(32), .REGADDR(5)) eif();

  execute_operand_stage #(.XLEN(32), .REGADDR(5)) dut (
    .clk (clk),
    .rst (rst),
    .eif (eif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string fld, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s.%s got %h expected %h", tag, fld, act, want);
    end
  endtask

  // Monitor: one queued expectation is compared per falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, "SrcA",       eif.SrcA,       e.srca);
      chk(t, "SrcB",       eif.SrcB,       e.srcb);
      chk(t, "WriteDataE", eif.WriteDataE, e.wd);
      chk(t, "PCE",        eif.PCE,        e.pc);
      chk(t, "ALUControl", {28'd0, eif.ALUControl}, {28'd0, e.alu});
      chk(t, "RdE",        {27'd0, eif.RdE},        {27'd0, e.rd});
      chk(t, "RegWriteE",  {31'd0, eif.RegWriteE},  {31'd0, e.rw});
      chk(t, "ValidE",     {31'd0, eif.ValidE},     {31'd0, e.v});
      chk(t, "ForwardAE",  {30'd0, eif.ForwardAE},  {30'd0, e.fa});
      chk(t, "ForwardBE",  {30'd0, eif.ForwardBE},  {30'd0, e.fb});
    end
  end

  task automatic expect_out(input string tag, input logic [31:0] srca, input logic [31:0] srcb,
                            input logic [31:0] wd, input logic [31:0] pc, input logic [3:0] alu,
                            input logic [4:0] rd, input logic rw, input logic v,
                            input logic [1:0] fa, input logic [1:0] fb);
    exp_t e;
    e = '{srca: srca, srcb: srcb, wd: wd, pc: pc, alu: alu, rd: rd, rw: rw, v: v, fa: fa, fb: fb};
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic expect_empty(input string tag);
    expect_out(tag, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00);
  endtask

  task automatic drive_d(input logic v, input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] alu,
                         input logic sa, input logic sb, input logic rw);
    eif.ValidD = v;     eif.RD1D = rd1;    eif.RD2D = rd2;
    eif.Rs1D = rs1;     eif.Rs2D = rs2;    eif.RdD = rd;
    eif.ImmExtD = imm;  eif.PCD = pc;      eif.ALUControlD = alu;
    eif.ALUSrcAD = sa;  eif.ALUSrcBD = sb; eif.RegWriteD = rw;
  endtask

  task automatic drive_mw(input logic [31:0] resm, input logic [4:0] rdm, input logic wm,
                          input logic [31:0] resw, input logic [4:0] rdw, input logic ww);
    eif.ALUResultM = resm; eif.RdM = rdm; eif.RegWriteM = wm;
    eif.ResultW = resw;    eif.RdW = rdw; eif.RegWriteW = ww;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    eif.StallE = 1'b0;
    eif.FlushE = 1'b0;
    drive_d(1'b0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 1'b0, 1'b0, 1'b0);
    drive_mw(0, 0, 1'b0, 0, 0, 1'b0);

    tick();
    expect_empty("reset");
    rst = 1'b0;
    drive_d(1'b1, 32'd5, 32'd7, 5'd1, 5'd2, 5'd4, 32'd0, 32'h100, 4'b0000, 1'b0, 1'b0, 1'b1);

    tick();
    expect_out("basic_add", 32'd5, 32'd7, 32'd7, 32'h100, 4'b0000, 5'd4, 1'b1, 1'b1, 2'b00, 2'b00);
    drive_d(1'b1, 32'hAA, 32'hBB, 5'd3, 5'd0, 5'd5, 32'hFFFF_FFFC, 32'h104, 4'b0010, 1'b0, 1'b1, 1'b1);

    tick();
    drive_mw(32'h11, 5'd3, 1'b1, 32'h22, 5'd3, 1'b1);
    expect_out("mem_over_wb", FWD ? 32'h11 : 32'hAA, 32'hFFFF_FFFC, 32'hBB, 32'h104, 4'b0010,
               5'd5, 1'b1, 1'b1, FWD ? 2'b10 : 2'b00, 2'b00);
    eif.StallE = 1'b1;
    drive_d(1'b1, 32'hDEAD, 32'hBEEF, 5'd11, 5'd12, 5'd13, 32'h1, 32'h999, 4'b0111, 1'b1, 1'b0, 1'b1);

    tick();
    drive_mw(32'h11, 5'd3, 1'b0, 32'h22, 5'd3, 1'b1);
    expect_out("wb_while_stalled", FWD ? 32'h22 : 32'hAA, 32'hFFFF_FFFC, 32'hBB, 32'h104, 4'b0010,
               5'd5, 1'b1, 1'b1, FWD ? 2'b01 : 2'b00, 2'b00);
    drive_d(1'b1, 32'h1234, 32'h5678, 5'd14, 5'd15, 5'd16, 32'h2, 32'h888, 4'b0101, 1'b0, 1'b1, 1'b0);

    tick();
    drive_mw(32'h11, 5'd0, 1'b1, 32'h22, 5'd3, 1'b0);
    expect_out("x0_guard_stalled", 32'hAA, 32'hFFFF_FFFC, 32'hBB, 32'h104, 4'b0010,
               5'd5, 1'b1, 1'b1, 2'b00, 2'b00);
    eif.StallE = 1'b0;
    drive_d(1'b1, 32'h30, 32'h40, 5'd6, 5'd7, 5'd8, 32'h10, 32'h108, 4'b0001, 1'b1, 1'b0, 1'b1);

    tick();
    drive_mw(32'h77, 5'd7, 1'b1, 32'h66, 5'd6, 1'b1);
    expect_out("pc_src_fwd_b", 32'h108, FWD ? 32'h77 : 32'h40, FWD ? 32'h77 : 32'h40, 32'h108,
               4'b0001, 5'd8, 1'b1, 1'b1, FWD ? 2'b01 : 2'b00, FWD ? 2'b10 : 2'b00);
    drive_d(1'b0, 32'h55, 32'h66, 5'd6, 5'd7, 5'd9, 32'h3, 32'h10C, 4'b0011, 1'b0, 1'b0, 1'b1);

    tick();
    expect_empty("invalid_d_bubble");
    drive_d(1'b1, 32'h99, 32'h9A, 5'd9, 5'd10, 5'd9, 32'h0, 32'h110, 4'b1001, 1'b0, 1'b0, 1'b1);

    tick();
    drive_mw(0, 0, 1'b0, 0, 0, 1'b0);
    expect_out("sltu_load", 32'h99, 32'h9A, 32'h9A, 32'h110, 4'b1001, 5'd9, 1'b1, 1'b1, 2'b00, 2'b00);
    eif.StallE = 1'b1;
    eif.FlushE = 1'b1;
    drive_d(1'b1, 32'h1, 32'h2, 5'd1, 5'd2, 5'd3, 32'h4, 32'h114, 4'b0100, 1'b0, 1'b0, 1'b1);

    tick();
    expect_empty("flush_beats_stall");
    eif.StallE = 1'b0;
    eif.FlushE = 1'b0;
    drive_d(1'b1, 32'h5, 32'h7, 5'd2, 5'd3, 5'd1, 32'h0, 32'h200, 4'b0000, 1'b0, 1'b0, 1'b1);

    tick();
    expect_out("add_before_rst", 32'h5, 32'h7, 32'h7, 32'h200, 4'b0000, 5'd1, 1'b1, 1'b1, 2'b00, 2'b00);
    eif.StallE = 1'b1;

    tick();
    rst = 1'b1;
    expect_empty("async_rst_mid_stall");

    tick();
    expect_empty("rst_held");
    rst = 1'b0;
    eif.StallE = 1'b0;
    drive_d(1'b1, 32'hC0, 32'hC1, 5'd20, 5'd21, 5'd22, 32'h0, 32'h300, 4'b1111, 1'b0, 1'b1, 1'b1);

    tick();
    expect_out("first_load_after_rst", 32'hC0, 32'h0, 32'hC1, 32'h300, 4'b1111, 5'd22, 1'b1, 1'b1,
               2'b00, 2'b00);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      tick();
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain %0d expectations left, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_operand_stage.md
# execute_operand_stage

ID/EX pipeline register and operand-forwarding front end for the execute stage. Captures decoded operands and control at each clock edge, resolves RAW hazards by forwarding from the MEM and WB stages, and drives `SrcA`, `SrcB` and `ALUControl` directly into the ALU. Supports stall (hold) and flush (bubble insertion) from the hazard unit.

## Interface
Parameters:
- `XLEN`, 32: datapath width.
- `REGADDR`, 5: register index width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `StallE`  in  1  hold all stage registers.
- `FlushE`  in  1  load a bubble on the next edge.
- `ValidD`  in  1  decode-stage instruction is valid.
- `RD1D`, `RD2D`  in  XLEN  register-file read data.
- `Rs1D`, `Rs2D`, `RdD`  in  REGADDR  source and destination indices.
- `ImmExtD`  in  XLEN  sign-extended immediate.
- `PCD`  in  XLEN  instruction PC.
- `ALUControlD`  in  4  ALU operation code (0000 ADD … 1001 SLTU, 1111 pass-B).
- `ALUSrcAD`  in  1  SrcA select: 0 = rs1, 1 = PC.
- `ALUSrcBD`  in  1  SrcB select: 0 = rs2, 1 = immediate.
- `RegWriteD`  in  1  instruction writes `rd`.
- `ALUResultM`, `RdM`, `RegWriteM`  in  XLEN/REGADDR/1  MEM-stage forwarding source.
- `ResultW`, `RdW`, `RegWriteW`  in  XLEN/REGADDR/1  WB-stage forwarding source.
- `SrcA`, `SrcB`  out  XLEN  ALU operands.
- `ALUControl`  out  4  registered ALU operation.
- `WriteDataE`  out  XLEN  forwarded rs2 value, used as store data.
- `RdE`, `RegWriteE`, `ValidE`  out  REGADDR/1/1  registered destination, write enable and valid.
- `PCE`  out  XLEN  registered PC.
- `ForwardAE`, `ForwardBE`  out  2  forwarding selects: 00 = register file, 01 = WB, 10 = MEM.

## Operation
- Stage registers: Valid, RD1, RD2, Rs1, Rs2, Rd, ImmExt, PC, ALUControl, ALUSrcA, ALUSrcB, RegWrite.
- Edge update priority: `rst` > `FlushE` > `StallE` > load.
  - Load: capture all D inputs.
  - Stall: all registers hold.
  - Flush: bubble.
- Bubble and reset state: every register is 0. This gives `ValidE`=0, `RegWriteE`=0, `RdE`=0, `ALUControl`=0000, and `SrcA`=`SrcB`=`WriteDataE`=`PCE`=0.
- A D input with `ValidD`=0 loads as a bubble (`RegWriteE` is forced to 0).
- ForwardAE (combinational, from registered Rs1E):
  - 10 if `RegWriteM` && `RdM`≠0 && `RdM`==Rs1E;
  - else 01 if `RegWriteW` && `RdW`≠0 && `RdW`==Rs1E;
  - else 00.
  - MEM takes priority over WB when both match.
- ForwardBE: same rule, using Rs2E.
- Both selects are forced to 00 when `ValidE`=0.
- Operand paths:
  - FwdA = mux(ForwardAE: RD1E, ResultW, ALUResultM). FwdB is formed the same way from RD2E.
  - `SrcA` = ALUSrcAE ? PCE : FwdA.
  - `SrcB` = ALUSrcBE ? ImmExtE : FwdB.
  - `WriteDataE` = FwdB, independent of ALUSrcBE.
- Forwarding is re-evaluated every cycle, including while stalled. A held instruction picks up producer results as they advance.
- x0 is never forwarded; reads of x0 use RD1E/RD2E, which the register file returns as 0.

## Timing
- D inputs appear on E outputs one cycle after the capturing edge.
- `SrcA`, `SrcB`, `WriteDataE` and `Forward*E` are combinational from the stage registers and the M/W inputs. They add no latency.
- `rst` clears all outputs asynchronously, without waiting for an edge. On deassertion, the first edge with no stall and no flush loads D.
- `FlushE` and `StallE` asserted together: flush wins, and a bubble is loaded.
- Reset mid-stall or mid-flush: reset wins, and the stage is empty afterward.

## Configuration
- `EXEC_FORWARDING_EN` defined: forwarding logic as described above.
- Not defined:
  - `ForwardAE`=`ForwardBE`=00 permanently.
  - FwdA = RD1E and FwdB = RD2E.
  - The hazard unit must stall on all RAW hazards.
  - Stage register and stall/flush behaviour are unchanged.

## Test plan
- Reset: assert `rst` mid-cycle with the stage holding a valid ADD → all outputs 0 immediately; `ValidE`=0.
- Basic load: RD1D=5, RD2D=7, ALUControlD=0000, ALUSrcBD=0, ValidD=1 → next cycle `SrcA`=5, `SrcB`=7, `ALUControl`=0000.
- MEM-over-WB priority: Rs1E=3; RdM=RdW=3, both RegWrite=1; ALUResultM=0x11, ResultW=0x22 → `ForwardAE`=10, `SrcA`=0x11. With RegWriteM=0 → `ForwardAE`=01, `SrcA`=0x22.
- x0 guard and immediate select: Rs2E=0, RdM=0, RegWriteM=1 → `ForwardBE`=00. With ALUSrcBE=1 and ImmExtE=0xFFFFFFFC → `SrcB`=0xFFFFFFFC, while `WriteDataE` still shows FwdB.
- Stall/flush: `StallE`=1 for 2 cycles → E registers unchanged while D inputs toggle. `StallE`=`FlushE`=1 together → bubble, `RegWriteE`=0.
- With `EXEC_FORWARDING_EN` undefined: rerun the priority case → `ForwardAE`=00, `SrcA`=RD1E.
